// File: rtl/pipe_hazard_ctrl.sv
// Issue/stall controller for the IF/ID/EX-WB pipeline.
// Scoreboard of pending writebacks, bubble injection, flush drain, hang detect.
module pipe_hazard_ctrl #(
  parameter int NREG      = 16,
  parameter int BYPASS    = 1,
  parameter int FLUSH_CYC = 2,
  parameter int MAX_STALL = 15,
  localparam int RW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [1:0]      id_opcode,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  input  logic [RW-1:0]   id_rd,
  input  logic            wb_we,
  input  logic [RW-1:0]   wb_rd,
  input  logic            flush,
  output logic            stall,
  output logic            ex_bubble,
  output logic            issue,
  output logic [NREG-1:0] busy_vec,
  output logic [15:0]     stall_cnt,
  output logic            hang_err
);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  logic [1:0]      state, state_nxt;
  logic [7:0]      fcnt, fcnt_nxt;
  logic [7:0]      run_cnt;
  logic [NREG-1:0] busy_nxt, busy_eff;
  logic [NREG-1:0] wb_hot, id_hot;
  logic            src_busy, waw, hazard;
  logic            active, cnt_stall;

  assign wb_hot = wb_we ? (ONE << wb_rd) : '0;
  assign id_hot = ONE << id_rd;

  // A same-cycle commit releases the dependent only when bypass is on.
  assign busy_eff = (BYPASS != 0) ? (busy_vec & ~wb_hot) : busy_vec;

  assign src_busy = ~id_opcode[1] &
                    (busy_eff[id_rs1] | busy_eff[id_rs2]);
  assign waw      = busy_eff[id_rd];
  assign hazard   = id_valid & (id_opcode != 2'b11) &
                    (src_busy | waw);

  assign active    = (state == S_RUN) | (state == S_STALL);
  assign cnt_stall = stall & active;

  always_comb begin
    stall     = 1'b0;
    ex_bubble = 1'b1;
    issue     = 1'b0;
    if (rst || state == S_INIT) begin
      stall = 1'b1;
    end else if (flush || state == S_FLUSH) begin
      stall = 1'b0;
    end else if (hazard) begin
      stall = 1'b1;
    end else begin
      issue     = id_valid;
      ex_bubble = ~id_valid;
    end
  end

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = 8'd0;
    if (flush) begin
      state_nxt = S_FLUSH;
    end else begin
      unique case (state)
        S_INIT:  state_nxt = S_RUN;
        S_RUN,
        S_STALL: state_nxt = hazard ? S_STALL : S_RUN;
        S_FLUSH: begin
          if (fcnt == 8'(FLUSH_CYC - 1)) begin
            state_nxt = S_RUN;
          end else begin
            fcnt_nxt = fcnt + 8'd1;
          end
        end
        default: state_nxt = S_INIT;
      endcase
    end
  end

  // Commit clears first, issue sets last, so a same-reg pair stays busy.
  always_comb begin
    busy_nxt = (busy_vec & ~wb_hot);
    if (issue && id_opcode != 2'b11) begin
      busy_nxt = busy_nxt | id_hot;
    end
    if (flush || state == S_FLUSH) begin
      busy_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      fcnt      <= 8'd0;
      busy_vec  <= '0;
      stall_cnt <= 16'd0;
      run_cnt   <= 8'd0;
      hang_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      fcnt     <= fcnt_nxt;
      busy_vec <= busy_nxt;
      if (cnt_stall && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (cnt_stall) begin
        if (run_cnt != 8'hFF) begin
          run_cnt <= run_cnt + 8'd1;
        end
        if ({1'b0, run_cnt} + 9'd1 >= 9'(MAX_STALL)) begin
          hang_err <= 1'b1;
        end
      end else begin
        run_cnt <= 8'd0;
      end
    end
  end

endmodule
